memc_drain: RTL and testbench
=============================

# memc_drain

Result-side drain buffer for the systolic matrix-multiply datapath. The array emits each row of C skewed across columns: lane j of a row arrives j cycles after lane 0. This block deskews those lanes, assembles complete DIM-wide rows into an internal DIM×DIM buffer, and serves registered row reads by address. It is the unloading counterpart of the A/B input staging memories, which skew data going into the array.

## Interface
- BITS_C, 16, signed width of one C element
- DIM, 8, array dimension: lanes per row and rows per buffer
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  lane 0 of a new C row is present on Cin[0] this cycle
- Cin  in  BITS_C×DIM (signed, unpacked [DIM-1:0])  skewed array outputs; Cin[j] carries row data j cycles after in_valid
- clear  in  1  synchronous flush back to IDLE
- rd_en  in  1  read request
- Crow  in  $clog2(DIM)  row address for the read
- Cout  out  BITS_C×DIM (signed, unpacked [DIM-1:0])  registered read data
- rows_written  out  $clog2(DIM)+1  count of rows assembled, 0..DIM
- done  out  1  high while all DIM rows are held (state FULL)
- overflow  out  1  sticky; set when in_valid arrives in FULL
- rd_err  out  1  one-cycle flag; exists only with MEMC_DRAIN_ROWCHK_EN

## Operation
- Deskew:
  - Lane j passes through DIM-1-j pipeline registers; lane DIM-1 has no delay.
  - in_valid passes through a DIM-1 deep valid shift register.
  - The aligned row is valid when the tail of the valid shift register (vld_d) is high.
- Write:
  - When vld_d is high and state is not FULL, the aligned row is written to buffer[wr_ptr].
  - Then wr_ptr and rows_written increment.
- FSM:
  - IDLE (wr_ptr=0, rows_written=0) → CAPTURE on the first write.
  - CAPTURE → FULL on the write that makes rows_written=DIM.
  - FULL holds until clear or rst.
- The deskew pipeline runs in every state, so back-to-back rows (in_valid high on consecutive cycles) are accepted at one row per cycle.
- Behaviour in FULL: a vld_d row is dropped and overflow is set. The buffer is unchanged and wr_ptr does not wrap.
- clear:
  - Next state is IDLE; wr_ptr, rows_written and done go to 0.
  - The valid shift register is zeroed, so in-flight partial rows are discarded.
  - Buffer contents and Cout are not cleared.
  - overflow is cleared.
  - clear and in_valid in the same cycle: clear wins and the sample is dropped.
- Read:
  - rd_en=1 loads Cout with buffer[Crow] on the next edge.
  - When rd_en=0, Cout holds its value.
  - A read and a write to the same row in the same cycle return the old contents (read-before-write).
- Arithmetic: none. Data is stored bit-exact and sign is preserved.
- Reset values: Cout all lanes 0, rows_written 0, done 0, overflow 0, rd_err 0. The FSM, pointers and valid pipeline go to IDLE/0. Buffer contents are not reset.

## Timing
- in_valid at cycle T (lane 0) with Cin[j] at cycle T+j → the row is written at the edge ending cycle T+DIM-1.
- rows_written reflects that write in cycle T+DIM.
- Earliest read of that row: rd_en in cycle T+DIM, Cout valid in cycle T+DIM+1.
- done rises in the cycle after the DIM-th write and stays high until clear or rst.
- Read latency is 1 cycle; reads are accepted every cycle.
- rst asserted mid-capture aborts immediately, asynchronously. Partial rows are lost and the block returns to the reset values above.

## Configuration
- Macro MEMC_DRAIN_ROWCHK_EN.
- Defined:
  - A read with Crow ≥ rows_written returns all-zero Cout.
  - rd_err pulses high in the same cycle Cout updates.
- Undefined:
  - rd_err is absent.
  - Reads of unwritten rows return the stale buffer contents.
  - There is no range check.

## Test plan
- Single row (DIM=8, BITS_C=16): in_valid at T=0, Cin[j]=100+j at cycle j → rows_written=1 at cycle 8. rd_en, Crow=0 at cycle 8 → Cout={100..107} at cycle 9.
- Full matrix: 8 back-to-back rows with values r*16+j → done rises at cycle 15. Reading every row returns the exact values, including negative values such as 0x8000.
- Overflow: a 9th in_valid after FULL → overflow=1 one cycle after vld_d, buffer unchanged, rows_written=8.
- Clear race: clear in the same cycle as in_valid of row 3 → state IDLE, rows_written=0. The row is not written; the next row lands at buffer[0].
- Reset mid-capture: rst during row 2 skew → Cout=0, done=0. After release, a fresh row writes buffer[0].
- ROWCHK: with the macro defined and rows_written=2, read Crow=5 → Cout all zero and rd_err=1 for one cycle. Without the macro, stale data is returned.

Source files
------------

// File: rtl/memc_drain.sv
// Drain buffer for the systolic array: deskews C rows, stores DIM rows, serves registered reads.
// Optional MEMC_DRAIN_ROWCHK_EN adds a range check on reads and the rd_err flag.
module memc_drain #(
   parameter int BITS_C = 16,
   parameter int DIM    = 8
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       in_valid,
   input  logic signed [BITS_C-1:0]   Cin [DIM-1:0],
   input  logic                       clear,
   input  logic                       rd_en,
   input  logic [$clog2(DIM)-1:0]     Crow,
   output logic signed [BITS_C-1:0]   Cout [DIM-1:0],
   output logic [$clog2(DIM):0]       rows_written,
   output logic                       done,
   output logic                       overflow
`ifdef MEMC_DRAIN_ROWCHK_EN
   ,
   output logic                       rd_err
`endif
);

   localparam int AW = $clog2(DIM);
   localparam int CW = AW + 1;
   localparam int RW = DIM * BITS_C;
   localparam logic [CW-1:0] DIM_CNT = CW'(DIM);

   typedef enum logic [1:0] {IDLE, CAPTURE, FULL} state_t;

   state_t                    state_reg, state_next;
   logic [CW-1:0]             rows_next;
   logic                      ovf_next;
   logic                      wr_en;
   logic [DIM-2:0]            vld_sr;
   logic                      vld_d;
   logic signed [BITS_C-1:0]  row_aligned [DIM-1:0];
   logic [RW-1:0]             row_packed;
   logic [RW-1:0]             buffer [DIM-1:0];
   logic [RW-1:0]             rd_row;

   // Lane gi arrives gi cycles late, so it waits DIM-1-gi cycles to line up with the last lane.
   genvar gi;
   generate
      for (gi = 0; gi < DIM; gi++) begin : g_lane
         localparam int DEPTH = DIM - 1 - gi;
         if (DEPTH == 0) begin : g_pass
            assign row_aligned[gi] = Cin[gi];
         end else begin : g_dly
            logic signed [BITS_C-1:0] pipe [DEPTH];
            always_ff @(posedge clk) begin
               pipe[0] <= Cin[gi];
               for (int k = 1; k < DEPTH; k++) pipe[k] <= pipe[k-1];
            end
            assign row_aligned[gi] = pipe[DEPTH-1];
         end
         assign row_packed[gi*BITS_C +: BITS_C] = row_aligned[gi];
      end
   endgenerate

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vld_sr <= '0;
      end else if (clear) begin
         vld_sr <= '0;
      end else begin
         vld_sr[0] <= in_valid;
         for (int k = 1; k < DIM - 1; k++) vld_sr[k] <= vld_sr[k-1];
      end
   end

   assign vld_d = vld_sr[DIM-2];

   always_comb begin
      state_next = state_reg;
      rows_next  = rows_written;
      ovf_next   = overflow;
      wr_en      = 1'b0;
      if (clear) begin
         state_next = IDLE;
         rows_next  = '0;
         ovf_next   = 1'b0;
      end else if (vld_d) begin
         if (state_reg == FULL) begin
            ovf_next = 1'b1;
         end else begin
            wr_en      = 1'b1;
            rows_next  = rows_written + CW'(1);
            state_next = (rows_next == DIM_CNT) ? FULL : CAPTURE;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg    <= IDLE;
         rows_written <= '0;
         overflow     <= 1'b0;
      end else begin
         state_reg    <= state_next;
         rows_written <= rows_next;
         overflow     <= ovf_next;
      end
   end

   assign done = (state_reg == FULL);

   // rows_written doubles as the write pointer; it never advances past DIM.
   always_ff @(posedge clk) begin
      if (wr_en) buffer[rows_written[AW-1:0]] <= row_packed;
   end

   assign rd_row = buffer[Crow];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int k = 0; k < DIM; k++) Cout[k] <= '0;
      end else if (rd_en) begin
`ifdef MEMC_DRAIN_ROWCHK_EN
         if ({1'b0, Crow} >= rows_written) begin
            for (int k = 0; k < DIM; k++) Cout[k] <= '0;
         end else begin
            for (int k = 0; k < DIM; k++) Cout[k] <= rd_row[k*BITS_C +: BITS_C];
         end
`else
         for (int k = 0; k < DIM; k++) Cout[k] <= rd_row[k*BITS_C +: BITS_C];
`endif
      end
   end

`ifdef MEMC_DRAIN_ROWCHK_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) rd_err <= 1'b0;
      else     rd_err <= rd_en && ({1'b0, Crow} >= rows_written);
   end
`endif

endmodule

// File: tb/tb_memc_drain.sv
// Bench for memc_drain: directed scenarios with literal expectations, then random traffic
// checked every cycle against a row-level model (start-time queue, row store, counters).
module tb_memc_drain;
   localparam int BITS_C = 16;
   localparam int DIM    = 8;
   localparam int MAXC   = 4000;
`ifdef MEMC_DRAIN_ROWCHK_EN
   localparam bit ROWCHK = 1'b1;
`else
   localparam bit ROWCHK = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic in_valid = 1'b0;
   logic clear = 1'b0;
   logic rd_en = 1'b0;
   logic [2:0] Crow = '0;
   logic signed [BITS_C-1:0] Cin  [DIM-1:0];
   logic signed [BITS_C-1:0] Cout [DIM-1:0];
   logic [3:0] rows_written;
   logic done;
   logic overflow;
`ifdef MEMC_DRAIN_ROWCHK_EN
   logic rd_err;
`endif

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   memc_drain #(.BITS_C(BITS_C), .DIM(DIM)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .Cin(Cin), .clear(clear),
      .rd_en(rd_en), .Crow(Crow), .Cout(Cout), .rows_written(rows_written),
      .done(done), .overflow(overflow)
`ifdef MEMC_DRAIN_ROWCHK_EN
      , .rd_err(rd_err)
`endif
   );

   // stimulus bookkeeping: which cycles started a row and the row each one carried
   logic [15:0] row_data [MAXC][DIM];
   bit          started  [MAXC];
   logic [15:0] next_row [DIM];
   int          cyc = -1;
   bit          chk_en = 1'b0;

   // model state
   logic [15:0] m_buf [DIM][DIM];
   int          m_count = 0;
   bit          m_ovf = 1'b0;
   int          pend [$];
   logic [15:0] exp_cout [DIM];
   bit          exp_rderr = 1'b0;

   always @(posedge clk) begin
      if (rst) begin
         m_count = 0;
         m_ovf = 1'b0;
         pend.delete();
         for (int j = 0; j < DIM; j++) exp_cout[j] = '0;
         exp_rderr = 1'b0;
      end else begin
         if (rd_en) begin
            if (ROWCHK && int'(Crow) >= m_count) begin
               for (int j = 0; j < DIM; j++) exp_cout[j] = '0;
               exp_rderr = 1'b1;
            end else begin
               for (int j = 0; j < DIM; j++) exp_cout[j] = m_buf[Crow][j];
               exp_rderr = 1'b0;
            end
         end else begin
            exp_rderr = 1'b0;
         end
         if (clear) begin
            pend.delete();
            m_count = 0;
            m_ovf = 1'b0;
         end else begin
            if (in_valid) pend.push_back(cyc);
            if (pend.size() > 0 && pend[0] == cyc - (DIM - 1)) begin
               int s;
               s = pend.pop_front();
               if (m_count < DIM) begin
                  for (int j = 0; j < DIM; j++) m_buf[m_count][j] = row_data[s][j];
                  m_count++;
               end else begin
                  m_ovf = 1'b1;
               end
            end
         end
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         bit bad;
         int lane;
         bad = 1'b0;
         lane = 0;
         for (int j = 0; j < DIM; j++) begin
            if (Cout[j] !== exp_cout[j] && !bad) begin
               bad = 1'b1;
               lane = j;
            end
         end
         checks++;
         if (bad) begin
            failures++;
            $display("FAIL cout cyc=%0d lane=%0d actual=%h required=%h", cyc, lane, Cout[lane], exp_cout[lane]);
         end
         checks++;
         if (int'(rows_written) != m_count) begin
            failures++;
            $display("FAIL rows_written cyc=%0d actual=%0d required=%0d", cyc, rows_written, m_count);
         end
         checks++;
         if (done !== (m_count == DIM)) begin
            failures++;
            $display("FAIL done cyc=%0d actual=%0b required=%0b", cyc, done, (m_count == DIM));
         end
         checks++;
         if (overflow !== m_ovf) begin
            failures++;
            $display("FAIL overflow cyc=%0d actual=%0b required=%0b", cyc, overflow, m_ovf);
         end
`ifdef MEMC_DRAIN_ROWCHK_EN
         checks++;
         if (rd_err !== exp_rderr) begin
            failures++;
            $display("FAIL rd_err cyc=%0d actual=%0b required=%0b", cyc, rd_err, exp_rderr);
         end
`endif
      end
   end

   task automatic drive(input bit iv, input bit clr, input bit rd, input int addr, input bit rs);
      @(negedge clk);
      #1;
      cyc++;
      rst = rs;
      in_valid = iv;
      clear = clr;
      rd_en = rd;
      Crow = addr[2:0];
      started[cyc] = iv;
      if (iv) for (int j = 0; j < DIM; j++) row_data[cyc][j] = next_row[j];
      for (int j = 0; j < DIM; j++) begin
         int s;
         s = cyc - j;
         if (s >= 0 && started[s]) Cin[j] = row_data[s][j];
         else Cin[j] = 16'($urandom);
      end
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, 0, 1'b0);
   endtask

   task automatic set_row(input int base);
      for (int j = 0; j < DIM; j++) next_row[j] = 16'(base + j);
   endtask

   function automatic logic [DIM*16-1:0] pat_row(input int base);
      logic [DIM*16-1:0] r;
      for (int j = 0; j < DIM; j++) r[j*16 +: 16] = 16'(base + j);
      return r;
   endfunction

   function automatic int fbase(input int r);
      return (r == 7) ? 'h8000 : r * 16;
   endfunction

   task automatic lit(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d", name, act, exp);
      end
   endtask

   task automatic lit_row(input string name, input logic [DIM*16-1:0] exp);
      logic [DIM*16-1:0] act;
      for (int j = 0; j < DIM; j++) act[j*16 +: 16] = Cout[j];
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   initial begin
      for (int j = 0; j < DIM; j++) Cin[j] = '0;
      drive(1'b0, 1'b0, 1'b0, 0, 1'b1);
      drive(1'b0, 1'b0, 1'b0, 0, 1'b1);
      drive(1'b0, 1'b0, 1'b0, 0, 1'b0);
      chk_en = 1'b1;
      lit("rst_rows", rows_written, 0);
      lit("rst_done", done, 0);
      lit("rst_ovf", overflow, 0);
      lit_row("rst_cout", '0);

      // single row: lanes 100..107
      set_row(100);
      drive(1'b1, 1'b0, 1'b0, 0, 1'b0);
      idle(7);
      lit("row1_rows_pre", rows_written, 0);
      drive(1'b0, 1'b0, 1'b1, 0, 1'b0);
      lit("row1_rows", rows_written, 1);
      idle(1);
      lit_row("row1_cout", pat_row(100));

      // full matrix, back to back, row 7 negative
      drive(1'b0, 1'b1, 1'b0, 0, 1'b0);
      for (int i = 0; i < 16; i++) begin
         if (i < 8) set_row(fbase(i));
         drive(i < 8, 1'b0, 1'b0, 0, 1'b0);
         if (i == 14) lit("full_done_early", done, 0);
         if (i == 15) begin
            lit("full_done", done, 1);
            lit("full_rows", rows_written, 8);
         end
      end
      for (int r = 0; r <= 8; r++) begin
         drive(1'b0, 1'b0, r < 8, (r < 8) ? r : 0, 1'b0);
         if (r > 0) lit_row($sformatf("full_row%0d", r - 1), pat_row(fbase(r - 1)));
      end

      // overflow: a ninth row while FULL
      set_row('h5550);
      drive(1'b1, 1'b0, 1'b0, 0, 1'b0);
      idle(6);
      drive(1'b0, 1'b0, 1'b0, 0, 1'b0);
      lit("ovf_before", overflow, 0);
      drive(1'b0, 1'b0, 1'b1, 0, 1'b0);
      lit("ovf_set", overflow, 1);
      lit("ovf_rows", rows_written, 8);
      idle(1);
      lit_row("ovf_row0_kept", pat_row(fbase(0)));

      // clear racing with in_valid
      drive(1'b0, 1'b1, 1'b0, 0, 1'b0);
      idle(1);
      lit("clr_ovf", overflow, 0);
      lit("clr_done", done, 0);
      set_row('h0A00); drive(1'b1, 1'b0, 1'b0, 0, 1'b0);
      set_row('h0B00); drive(1'b1, 1'b0, 1'b0, 0, 1'b0);
      set_row('h0C00); drive(1'b1, 1'b0, 1'b0, 0, 1'b0);
      idle(8);
      lit("race_rows3", rows_written, 3);
      set_row('h0D00);
      drive(1'b1, 1'b1, 1'b0, 0, 1'b0);
      idle(1);
      lit("race_rows0", rows_written, 0);
      idle(7);
      lit("race_dropped", rows_written, 0);
      set_row('h0E00);
      drive(1'b1, 1'b0, 1'b0, 0, 1'b0);
      idle(7);
      drive(1'b0, 1'b0, 1'b1, 0, 1'b0);
      lit("race_next_rows", rows_written, 1);
      idle(1);
      lit_row("race_next_row0", pat_row('h0E00));

      // reset in the middle of deskewing two rows
      set_row('h0F00); drive(1'b1, 1'b0, 1'b0, 0, 1'b0);
      set_row('h1000); drive(1'b1, 1'b0, 1'b0, 0, 1'b0);
      idle(2);
      drive(1'b0, 1'b0, 1'b0, 0, 1'b1);
      lit_row("rstm_cout", '0);
      lit("rstm_done", done, 0);
      lit("rstm_rows", rows_written, 0);
      drive(1'b0, 1'b0, 1'b0, 0, 1'b1);
      drive(1'b0, 1'b0, 1'b0, 0, 1'b0);
      set_row('h1100);
      drive(1'b1, 1'b0, 1'b0, 0, 1'b0);
      idle(7);
      drive(1'b0, 1'b0, 1'b1, 0, 1'b0);
      lit("rstm_fresh_rows", rows_written, 1);
      idle(1);
      lit_row("rstm_fresh_row0", pat_row('h1100));

      // read beyond rows_written
      set_row('h2200);
      drive(1'b1, 1'b0, 1'b0, 0, 1'b0);
      idle(8);
      lit("chk_rows2", rows_written, 2);
      drive(1'b0, 1'b0, 1'b1, 5, 1'b0);
      idle(1);
`ifdef MEMC_DRAIN_ROWCHK_EN
      lit_row("chk_zero", '0);
      lit("chk_rderr", rd_err, 1);
      idle(1);
      lit("chk_rderr_pulse", rd_err, 0);
`else
      lit_row("chk_stale", pat_row(fbase(5)));
`endif

      // random traffic against the model
      for (int n = 0; n < 1500; n++) begin
         bit rs, iv, clr, rd;
         rs  = ($urandom_range(0, 199) == 0);
         iv  = !rs && ($urandom_range(0, 9) < 6);
         clr = ($urandom_range(0, 39) == 0);
         rd  = 1'($urandom_range(0, 1));
         for (int j = 0; j < DIM; j++) next_row[j] = 16'($urandom);
         drive(iv, clr, rd, $urandom_range(0, DIM - 1), rs);
      end
      idle(3);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
